qam_mapper: RTL
===============

QAM_MAPPER -- requirements
Module: qam_mapper

Interface
REQ-001 SHALL have parameter SYM_PER_FRAME, default 64: output symbols per frame; even, at least 2.
REQ-002 SHALL have parameter SCALE, default 2048: unsigned 16-bit amplitude of the ±1 level; the ±3 level is 3*SCALE.
REQ-003 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port ap_rst  in  1  asynchronous reset, active-high.
REQ-005 SHALL have port data_in_TDATA  in  8  two 4-bit 16-QAM symbols; low nibble is sent first.
REQ-006 SHALL have ports data_in_TVALID in 1, data_in_TREADY out 1 and data_in_TLAST in 1 (input AXI4-Stream).
REQ-007 SHALL have port data_out_TDATA  out  32  symbol: I in [15:0], Q in [31:16], both two's complement.
REQ-008 SHALL have ports data_out_TVALID out 1, data_out_TREADY in 1 and data_out_TLAST out 1 (output AXI4-Stream).
REQ-009 SHALL have port data_in_TDATA_blk_n  out  1  low while starved on input.
REQ-010 SHALL have port data_out_TDATA_blk_n  out  1  low while back-pressured on output.
REQ-011 SHALL have port ap_idle  out  1  high when no data is held.
REQ-012 SHALL have port frame_err  out  1  sticky input-framing error flag.

Function
REQ-013 SHALL use a 3-state FSM: EMPTY (no byte held), LO (low-nibble symbol presented), HI (high-nibble symbol presented).
REQ-014 SHALL drive data_in_TREADY = (state==EMPTY) or (state==HI and data_out_TREADY).
REQ-015 SHALL, on an input handshake, register the byte and the low-nibble symbol on data_out_TDATA, assert data_out_TVALID on the next cycle, and enter LO.
REQ-016 SHALL move from LO to HI on an output handshake, presenting the high-nibble symbol on the next cycle.
REQ-017 SHALL, on an output handshake in HI, enter LO if an input handshake occurs in the same cycle, otherwise EMPTY with data_out_TVALID low; this gives a steady rate of 1 byte per 2 cycles with no bubble.
REQ-018 SHALL hold data_out_TDATA, data_out_TVALID and data_out_TLAST stable while data_out_TVALID=1 and data_out_TREADY=0.
REQ-019 SHALL Gray-map symbol bits [3:2] to I and [1:0] to Q: 00 to -3*SCALE, 01 to -SCALE, 11 to +SCALE, 10 to +3*SCALE, all truncated to 16 bits.
REQ-020 SHALL count output symbol handshakes modulo SYM_PER_FRAME and assert data_out_TLAST on the symbol at count SYM_PER_FRAME-1; the count then wraps to 0.
REQ-021 SHALL count input bytes modulo SYM_PER_FRAME/2 and set frame_err when data_in_TLAST=1 on a handshake at byte index other than SYM_PER_FRAME/2-1, or when data_in_TLAST=0 at that index.
REQ-022 SHALL drive data_in_TDATA_blk_n = ~(data_in_TREADY & ~data_in_TVALID) and data_out_TDATA_blk_n = ~(data_out_TVALID & ~data_out_TREADY).
REQ-023 SHALL drive ap_idle = (state==EMPTY); ap_idle is combinational from the state.
REQ-024 SHALL have a latency of 1 cycle from an input handshake to data_out_TVALID.

Reset
REQ-025 SHALL, on ap_rst assertion and regardless of the clock, set state=EMPTY, both counters=0, data_out_TVALID=0, data_out_TLAST=0, data_out_TDATA=0 and frame_err=0.
REQ-026 SHALL discard any held byte on reset mid-frame; the first byte after reset starts a new frame at index 0.
REQ-027 SHALL hold data_in_TREADY=1 and ap_idle=1 one cycle after reset release.

Structure
REQ-028 SHALL place the FSM state enum, the 2-bit Gray-to-level mapping function and the I/Q field offsets in a shared package, qam_pkg, which the deQAM side also imports.
REQ-029 SHALL contain one sub-module, qam_sym_map: combinational, 4-bit symbol plus SCALE to 32-bit I/Q word.

Verification
REQ-030 SHALL verify single-byte mapping: byte 0x1B with TREADY=1 -> 0x08001800, then 0xF800E800, on consecutive cycles; then ap_idle=1.
REQ-031 SHALL verify sustained throughput: 32 bytes, TVALID and TREADY held high -> 64 symbols, TREADY toggling 1010..., TLAST only on symbol 64, frame_err=0.
REQ-032 SHALL verify back-pressure: output TREADY low for 5 cycles on symbol 3 -> TDATA and TLAST stable, data_out_TDATA_blk_n=0 for those 5 cycles, no symbol lost or duplicated.
REQ-033 SHALL verify starvation: input TVALID low in EMPTY -> data_in_TDATA_blk_n=0 and ap_idle=1.
REQ-034 SHALL verify framing error: data_in_TLAST on byte index 5 -> frame_err rises the next cycle and stays set until ap_rst.
REQ-035 SHALL verify reset mid-operation: ap_rst asserted while in LO -> data_out_TVALID falls immediately, and the next frame has TLAST on symbol 64.

Source files
------------

// File: rtl/qam_pkg.sv
// ------------------------------------------------------------------
// qam_pkg : shared 16-QAM state encoding, Gray level map, I/Q layout
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package qam_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } qam_state_t;

    localparam int IQ_W  = 16;
    localparam int I_LSB = 0;
    localparam int Q_LSB = 16;

    // Gray order 00,01,11,10 walks -3,-1,+1,+3; results wrap to 16 bits
    function automatic logic [15:0] gray_level(input logic [1:0] bits,
                                               input logic [15:0] scale);
        logic [15:0] three;
        logic [15:0] level;
        three = scale + (scale << 1);
        case (bits)
            2'b00:   level = ~three + 16'd1;
            2'b01:   level = ~scale + 16'd1;
            2'b11:   level = scale;
            default: level = three;
        endcase
        return level;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam_sym_map.sv
// ------------------------------------------------------------------
// qam_sym_map : 4-bit 16-QAM symbol to packed {Q, I} word
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module qam_sym_map #(
    parameter logic [15:0] SCALE = 16'd2048
) (
    input  logic [3:0]  sym,
    output logic [31:0] iq
);
    import qam_pkg::*;

    always_comb begin
        iq = '0;
        iq[I_LSB +: IQ_W] = gray_level(sym[3:2], SCALE);
        iq[Q_LSB +: IQ_W] = gray_level(sym[1:0], SCALE);
    end

endmodule

`default_nettype wire

// File: rtl/qam_mapper.sv
// ------------------------------------------------------------------
// qam_mapper : byte stream to 16-QAM I/Q symbol stream, two per byte
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module qam_mapper #(
    parameter int          SYM_PER_FRAME = 64,
    parameter logic [15:0] SCALE         = 16'd2048
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [7:0]  data_in_TDATA,
    input  logic        data_in_TVALID,
    output logic        data_in_TREADY,
    input  logic        data_in_TLAST,
    output logic [31:0] data_out_TDATA,
    output logic        data_out_TVALID,
    input  logic        data_out_TREADY,
    output logic        data_out_TLAST,
    output logic        data_in_TDATA_blk_n,
    output logic        data_out_TDATA_blk_n,
    output logic        ap_idle,
    output logic        frame_err
);
    import qam_pkg::*;

    localparam int             CW        = (SYM_PER_FRAME > 2) ? $clog2(SYM_PER_FRAME) : 1;
    localparam logic [CW-1:0]  SYM_LAST  = CW'(SYM_PER_FRAME - 1);
    localparam logic [CW-1:0]  BYTE_LAST = CW'(SYM_PER_FRAME / 2 - 1);

    qam_state_t    state;
    qam_state_t    state_nxt;
    logic [3:0]    hi_nib;
    logic [CW-1:0] sym_cnt;
    logic [CW-1:0] sym_cnt_nxt;
    logic [CW-1:0] byte_cnt;
    logic [31:0]   lo_word;
    logic [31:0]   hi_word;
    logic          in_hs;
    logic          out_hs;
    logic          load_lo;
    logic          load_hi;

    qam_sym_map #(.SCALE(SCALE)) u_map_lo (
        .sym (data_in_TDATA[3:0]),
        .iq  (lo_word)
    );

    qam_sym_map #(.SCALE(SCALE)) u_map_hi (
        .sym (hi_nib),
        .iq  (hi_word)
    );

    assign data_in_TREADY       = (state == ST_EMPTY) || ((state == ST_HI) && data_out_TREADY);
    assign in_hs                = data_in_TVALID && data_in_TREADY;
    assign out_hs               = data_out_TVALID && data_out_TREADY;
    assign ap_idle              = (state == ST_EMPTY);
    assign data_in_TDATA_blk_n  = ~(data_in_TREADY & ~data_in_TVALID);
    assign data_out_TDATA_blk_n = ~(data_out_TVALID & ~data_out_TREADY);

    // Count reflects the index of the symbol presented after this edge
    assign sym_cnt_nxt = !out_hs ? sym_cnt :
                         (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        load_lo   = 1'b0;
        load_hi   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_nxt = ST_LO;
                    load_lo   = 1'b1;
                end
            end
            ST_LO: begin
                if (out_hs) begin
                    state_nxt = ST_HI;
                    load_hi   = 1'b1;
                end
            end
            ST_HI: begin
                if (out_hs) begin
                    if (in_hs) begin
                        state_nxt = ST_LO;
                        load_lo   = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state           <= ST_EMPTY;
            hi_nib          <= '0;
            sym_cnt         <= '0;
            byte_cnt        <= '0;
            data_out_TDATA  <= '0;
            data_out_TVALID <= 1'b0;
            data_out_TLAST  <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state   <= state_nxt;
            sym_cnt <= sym_cnt_nxt;
            if (in_hs) begin
                hi_nib   <= data_in_TDATA[7:4];
                byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + 1'b1;
                if (data_in_TLAST != (byte_cnt == BYTE_LAST)) begin
                    frame_err <= 1'b1;
                end
            end
            if (load_lo) begin
                data_out_TDATA  <= lo_word;
                data_out_TVALID <= 1'b1;
                data_out_TLAST  <= (sym_cnt_nxt == SYM_LAST);
            end else if (load_hi) begin
                data_out_TDATA  <= hi_word;
                data_out_TLAST  <= (sym_cnt_nxt == SYM_LAST);
            end else if ((state == ST_HI) && out_hs) begin
                data_out_TVALID <= 1'b0;
                data_out_TLAST  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
